// File: rtl/bram_operand_loader.sv
// Operand-buffer sequencer: streams {A,B} pairs into the low/high halves of a
// dual-port RAM, then replays them as registered operands with a 2-cycle read pipeline.
module bram_operand_loader #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*DATA_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    input  logic                  play,
    input  logic                  loop_en,
    input  logic                  stop,
    output logic                  busy,
    output logic [ADDR_W-1:0]     count,
    output logic [ADDR_W-1:0]     ram_addr1,
    output logic [ADDR_W-1:0]     ram_addr2,
    output logic                  ram_we1,
    output logic                  ram_we2,
    output logic [DATA_W-1:0]     ram_data1,
    output logic [DATA_W-1:0]     ram_data2,
    input  logic [DATA_W-1:0]     ram_out1,
    input  logic [DATA_W-1:0]     ram_out2,
    output logic [DATA_W-1:0]     op_a,
    output logic [DATA_W-1:0]     op_b,
    output logic                  op_valid
);

    localparam int PTR_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] HALF = {1'b1, {PTR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PLAY,
        ST_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                s2_q;
    logic                op_valid_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;

    logic                ready;
    logic                we;
    logic                issue;
    logic [PTR_W-1:0]    issue_ptr;
    logic                last;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ready     = 1'b0;
        we        = 1'b0;
        issue     = 1'b0;
        issue_ptr = rd_ptr_q;
        last      = ({1'b0, rd_ptr_q} == (count_q - ADDR_W'(1)));

        case (state_q)
            ST_LOAD: begin
                ready = reset && (count_q < HALF) && !play && !clear;
                if (clear) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (play && (count_q != '0)) begin
                    // Entry 0 is issued in the play cycle itself so op_valid
                    // appears two cycles after play; PLAY resumes at entry 1.
                    issue     = 1'b1;
                    issue_ptr = '0;
                    if ((count_q == ADDR_W'(1)) && !loop_en) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d  = ST_PLAY;
                        rd_ptr_d = (count_q == ADDR_W'(1)) ? '0 : PTR_W'(1);
                    end
                end else if (in_valid && ready) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + ADDR_W'(1);
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_FLUSH;
                end else begin
                    issue = 1'b1;
                    if (last) begin
                        if (loop_en) begin
                            rd_ptr_d = '0;
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end

            ST_FLUSH: begin
                if (!s2_q) begin
                    state_d = ST_LOAD;
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s2_q       <= 1'b0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s2_q       <= issue;
            op_valid_q <= s2_q;
            if (s2_q) begin
                op_a_q <= ram_out1;
                op_b_q <= ram_out2;
            end
        end
    end

    // RAM ports idle at zero unless writing or issuing a read.
    always_comb begin
        ram_we1   = we;
        ram_we2   = we;
        ram_addr1 = '0;
        ram_addr2 = '0;
        ram_data1 = '0;
        ram_data2 = '0;
        if (we) begin
            ram_addr1 = {1'b0, wr_ptr_q};
            ram_addr2 = {1'b1, wr_ptr_q};
            ram_data1 = in_data[DATA_W-1:0];
            ram_data2 = in_data[2*DATA_W-1:DATA_W];
        end else if (issue) begin
            ram_addr1 = {1'b0, issue_ptr};
            ram_addr2 = {1'b1, issue_ptr};
        end
    end

    assign in_ready = ready;
    assign busy     = (state_q != ST_LOAD);
    assign count    = count_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;

endmodule

// File: tb/tb_bram_operand_loader.sv
// Bench for bram_operand_loader: behavioural RAM, queue-based model of stored
// pairs and expected replay stream, table vectors plus directed corner cases.
module tb_bram_operand_loader;

    localparam int DW = 20;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*DW-1:0] in_data;
    logic            in_valid, in_ready, clear, play, loop_en, stop, busy;
    logic [AW-1:0]   count, ram_addr1, ram_addr2;
    logic            ram_we1, ram_we2;
    logic [DW-1:0]   ram_data1, ram_data2, ram_out1, ram_out2, op_a, op_b;
    logic            op_valid;

    bram_operand_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .play(play), .loop_en(loop_en),
        .stop(stop), .busy(busy), .count(count), .ram_addr1(ram_addr1),
        .ram_addr2(ram_addr2), .ram_we1(ram_we1), .ram_we2(ram_we2),
        .ram_data1(ram_data1), .ram_data2(ram_data2), .ram_out1(ram_out1),
        .ram_out2(ram_out2), .op_a(op_a), .op_b(op_b), .op_valid(op_valid)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with one-cycle read latency.
    logic [DW-1:0] mem [0:1023];
    int unsigned   bad_p1 = 0, bad_p2 = 0;
    always @(posedge clk) begin
        if (ram_we1) mem[ram_addr1] <= ram_data1;
        if (ram_we2) mem[ram_addr2] <= ram_data2;
        ram_out1 <= mem[ram_addr1];
        ram_out2 <= mem[ram_addr2];
        if (ram_we1 && ram_addr1[AW-1]) bad_p1++;
        if (ram_we2 && !ram_addr2[AW-1]) bad_p2++;
    end

    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } pair_t;
    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [AW-1:0] exp_count; logic [AW-1:0] exp_addr2; } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_busy = 0;
    pair_t       got_q[$];
    int unsigned got_cyc[$];
    pair_t       mdl[$];
    pair_t       exp_q[$];
    vec_t        tbl [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pair_t p;
        if (reset && op_valid) begin
            p.a = op_a;
            p.b = op_b;
            got_q.push_back(p);
            got_cyc.push_back(cyc);
        end
        if (busy) last_busy = cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one pair from a negedge until accepted; checks the write-port image.
    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit    ok;
        pair_t p;
        ok       = 1'b0;
        in_data  = {b, a};
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (in_ready) begin
                chk("wr_we", 64'({ram_we1, ram_we2}), 64'd3);
                chk("wr_addr1", 64'(ram_addr1), 64'(mdl.size()));
                chk("wr_addr2", 64'(ram_addr2), 64'(512 + mdl.size()));
                chk("wr_data", 64'({ram_data2, ram_data1}), 64'({b, a}));
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("push_accepted", 64'(ok), 64'd1);
        if (ok) begin
            p.a = a;
            p.b = b;
            mdl.push_back(p);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mdl.delete();
        chk("clear_count", 64'(count), 64'd0);
    endtask

    task automatic do_play(input bit lp, output int unsigned t);
        loop_en = lp;
        play    = 1'b1;
        t       = cyc;
        #1;
        chk("play_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({name, "_pair"}, 64'({got_q[i].b, got_q[i].a}), 64'({exp_q[i].b, exp_q[i].a}));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int unsigned n;
        bit          hs;
        bit          full_seen;
        pair_t       p;

        tbl[0] = '{a: 20'd1, b: 20'h100, exp_count: 10'd1, exp_addr2: 10'd512};
        tbl[1] = '{a: 20'd2, b: 20'h200, exp_count: 10'd2, exp_addr2: 10'd513};
        tbl[2] = '{a: 20'd3, b: 20'h300, exp_count: 10'd3, exp_addr2: 10'd514};

        reset = 1'b0; in_data = '0; in_valid = 1'b0; clear = 1'b0;
        play = 1'b0; loop_en = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ram", 64'({ram_we1, ram_we2, ram_addr1, ram_addr2}), 64'd0);
        chk("rst_ops", 64'({op_a, op_b}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Table-driven load of three pairs.
        for (int i = 0; i < 3; i++) begin
            push(tbl[i].a, tbl[i].b);
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_mem_a", 64'(mem[i]), 64'(tbl[i].a));
            chk("tbl_mem_b", 64'(mem[tbl[i].exp_addr2]), 64'(tbl[i].b));
        end

        // Single replay: op_valid on t+2..t+4, busy last high on t+4.
        got_q.delete(); got_cyc.delete();
        do_play(1'b0, t);
        repeat (10) @(negedge clk);
        exp_q = mdl;
        cmp_stream("play3");
        if (got_cyc.size() == 3) begin
            chk("play3_first_cyc", 64'(got_cyc[0]), 64'(t + 2));
            chk("play3_last_cyc", 64'(got_cyc[2]), 64'(t + 4));
        end
        chk("play3_busy_fall", 64'(last_busy), 64'(t + 4));
        chk("play3_count", 64'(count), 64'd3);

        // Random loads (optionally appending) followed by replay.
        for (int it = 0; it < 4; it++) begin
            if (it == 0 || $urandom_range(0, 1) == 1) pulse_clear();
            n = $urandom_range(1, 24);
            for (int j = 0; j < int'(n); j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(DW'($urandom), DW'($urandom));
            end
            chk("rnd_count", 64'(count), 64'(mdl.size()));
            got_q.delete(); got_cyc.delete();
            do_play(1'b0, t);
            repeat (mdl.size() + 8) @(negedge clk);
            exp_q = mdl;
            cmp_stream("rnd_play");
            if (got_cyc.size() > 0) chk("rnd_latency", 64'(got_cyc[0]), 64'(t + 2));
            chk("rnd_busy", 64'(busy), 64'd0);
        end

        // Fill to capacity with in_valid held high.
        pulse_clear();
        n = 0;
        full_seen = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 530; c++) begin
            in_data = {DW'(n + 1000), DW'(n)};
            #1;
            hs = in_ready;
            if (n == 512 && !full_seen) begin
                chk("full_ready", 64'(in_ready), 64'd0);
                full_seen = 1'b1;
            end
            @(negedge clk);
            if (hs) n++;
        end
        in_valid = 1'b0;
        chk("full_accepted", 64'(n), 64'd512);
        chk("full_count", 64'(count), 64'd512);
        chk("full_mem_a", 64'(mem[511]), 64'd511);
        chk("full_mem_b", 64'(mem[1023]), 64'd1511);
        chk("full_port1_high", 64'(bad_p1), 64'd0);

        // Looping replay of two pairs, stopped after five issued addresses.
        pulse_clear();
        push(tbl[0].a, tbl[0].b);
        push(tbl[1].a, tbl[1].b);
        got_q.delete(); got_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(mdl[i % 2]);
        do_play(1'b1, t);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (8) @(negedge clk);
        loop_en = 1'b0;
        cmp_stream("loop_stop");
        chk("loop_busy", 64'(busy), 64'd0);
        chk("loop_count", 64'(count), 64'd2);

        // play and clear together: clear wins.
        push(tbl[2].a, tbl[2].b);
        chk("pc_pre_count", 64'(count), 64'd3);
        got_q.delete();
        clear = 1'b1;
        do_play(1'b0, t);
        clear = 1'b0;
        mdl.delete();
        repeat (8) @(negedge clk);
        chk("pc_count", 64'(count), 64'd0);
        chk("pc_never_busy", 64'(last_busy < t), 64'd1);
        chk("pc_no_valid", 64'(got_q.size()), 64'd0);

        // Reset during the second op_valid of a replay.
        for (int i = 0; i < 3; i++) push(tbl[i].a, tbl[i].b);
        got_q.delete();
        do_play(1'b0, t);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_valid", 64'(op_valid), 64'd1);
        chk("mid_op_a", 64'(op_a), 64'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(op_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mdl.delete();
        @(negedge clk);
        #1;
        chk("mid_rel_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_we1", 64'(ram_we1), 64'd0);
        repeat (4) @(negedge clk);
        chk("mid_discarded", 64'(got_q.size()), 64'd2);
        chk("port2_low", 64'(bad_p2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
